// File: rtl/test_template_pkg.sv
// Shared defaults and helpers for the test_template serial pattern detector.
package test_template_pkg;

   localparam int         DEF_PAT_LEN = 4;
   localparam logic [3:0] DEF_PATTERN = 4'b1011;

   // Fill counter width: wide enough to hold PAT_LEN-1.
   function automatic int fill_width(input int pat_len);
      return $clog2(pat_len);
   endfunction

endpackage

// File: rtl/test_template_hist.sv
// History shift register (LSB newest) plus saturating fill counter,
// with async active-low clear and a synchronous restart clear.
module test_template_hist
   import test_template_pkg::*;
#(
   parameter int HIST_W = 3
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 din,
   input  logic                                 sync_clr,
   output logic [HIST_W-1:0]                    hist_q,
   output logic [fill_width(HIST_W + 1)-1:0]    fill_q
);

   localparam int                FILL_W   = fill_width(HIST_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_W);

   logic [HIST_W-1:0] hist_d;
   logic [FILL_W-1:0] fill_d;
   logic [HIST_W:0]   shifted;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      shifted = {hist_q, din};
      hist_d  = shifted[HIST_W-1:0];
      fill_d  = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      if (sync_clr) begin
         hist_d = '0;
         fill_d = '0;
      end
   end

   // NOTE: state flops use non-blocking assignments and reset asynchronously on rst_n low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/test_template.sv
// Serial Mealy pattern detector. Define TEST_TEMPLATE_OVERLAP_EN for
// overlapping detection; default restarts detection after each match.
module test_template
   import test_template_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic input1,
   output logic output1
);

   localparam int                FILL_W   = fill_width(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   generate
      if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
         $fatal(1, "test_template: PAT_LEN must be in 2..32");
      end
   endgenerate

   logic [PAT_LEN-2:0] hist_q;
   logic [FILL_W-1:0]  fill_q;
   logic [PAT_LEN-1:0] candidate;
   logic               match;
   logic               sync_clr;

   test_template_hist #(
      .HIST_W (PAT_LEN - 1)
   ) u_hist (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (input1),
      .sync_clr (sync_clr),
      .hist_q   (hist_q),
      .fill_q   (fill_q)
   );

   // Gating with rst_n keeps the flag low during reset, before the flops clear.
   always_comb begin
      candidate = {hist_q, input1};
      match     = rst_n & (fill_q == FILL_MAX) & (candidate == PATTERN);
`ifdef TEST_TEMPLATE_OVERLAP_EN
      sync_clr  = 1'b0;
`else
      sync_clr  = match;
`endif
   end

   assign output1 = match;

endmodule

// File: tb/tb_test_template.sv
// Vector-driven bench for test_template (default 4-bit 1011 instance and a
// 2-bit 11 instance); expectations follow TEST_TEMPLATE_OVERLAP_EN.
module tb_test_template;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in1 = 1'b0;
   logic out1;
   logic in2 = 1'b0;
   logic out2;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef TEST_TEMPLATE_OVERLAP_EN
   localparam logic OV = 1'b1;
`else
   localparam logic OV = 1'b0;
`endif

   always #5 clk = ~clk;

   test_template u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .input1  (in1),
      .output1 (out1)
   );

   test_template #(
      .PAT_LEN (2),
      .PATTERN (2'b11)
   ) u_dut2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .input1  (in2),
      .output1 (out2)
   );

   typedef struct {
      logic  rst_before;
      logic  din;
      logic  exp;
      string nm;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in1   = 1'b0;
      in2   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive a bit half a period before the consuming edge, sample shortly after.
   task automatic drive1(input logic b, input logic exp, input string nm);
      @(negedge clk);
      in1 = b;
      #2;
      check(nm, out1, exp);
   endtask

   task automatic drive2(input logic b, input logic exp, input string nm);
      @(negedge clk);
      in2 = b;
      #2;
      check(nm, out2, exp);
   endtask

   initial begin
      vecs.push_back('{1'b1, 1'b1, 1'b0, "basic_b1"});
      vecs.push_back('{1'b0, 1'b0, 1'b0, "basic_b2"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, "basic_b3"});
      vecs.push_back('{1'b0, 1'b1, 1'b1, "basic_b4"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, "ovl_b1"});
      vecs.push_back('{1'b0, 1'b0, 1'b0, "ovl_b2"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, "ovl_b3"});
      vecs.push_back('{1'b0, 1'b1, 1'b1, "ovl_b4"});
      vecs.push_back('{1'b0, 1'b0, 1'b0, "ovl_b5"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, "ovl_b6"});
      vecs.push_back('{1'b0, 1'b1, OV,   "ovl_b7"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, "near_b1"});
      vecs.push_back('{1'b0, 1'b0, 1'b0, "near_b2"});
      vecs.push_back('{1'b0, 1'b0, 1'b0, "near_b3"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, "near_b4"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, "near_b5"});

      // Reset held with input1 = 1: flag stays low throughout.
      rst_n = 1'b0;
      in1   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         check("rst_hold", out1, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive1(1'b1, 1'b0, "rst_rel_b1");
      drive1(1'b0, 1'b0, "rst_rel_b2");
      drive1(1'b1, 1'b0, "rst_rel_b3");

      foreach (vecs[i]) begin
         if (vecs[i].rst_before) do_reset();
         drive1(vecs[i].din, vecs[i].exp, vecs[i].nm);
      end

      // Reset mid-stream: 1,0,1 then reset while input1 = 1 would complete 1011.
      do_reset();
      drive1(1'b1, 1'b0, "mid_b1");
      drive1(1'b0, 1'b0, "mid_b2");
      drive1(1'b1, 1'b0, "mid_b3");
      @(posedge clk);
      #1;
      in1   = 1'b1;
      rst_n = 1'b0;
      #2;
      check("mid_in_reset", out1, 1'b0);
      rst_n = 1'b1;
      drive1(1'b1, 1'b0, "mid_post_b1");
      drive1(1'b0, 1'b0, "mid_post_b2");
      drive1(1'b1, 1'b0, "mid_post_b3");
      drive1(1'b1, 1'b1, "mid_post_b4");

      // PAT_LEN = 2, PATTERN = 11.
      do_reset();
      drive2(1'b1, 1'b0, "len2_b1");
      drive2(1'b1, 1'b1, "len2_b2");
      drive2(1'b1, OV,   "len2_b3");
      drive2(1'b1, 1'b1, "len2_b4");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
